register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath; next generation of the single-cycle two-read/one-write register file.
- Generalised in data width, depth and number of read ports.
- Adds a write-to-read bypass, programmable reset values for the stack and global pointers, and a sequenced bulk-clear mode with a busy flag.
- Sits between decode (addresses) and execute (operands); writeback drives the write port.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- SP_INDEX, 29, index loaded with SP_INIT on reset and clear.
- SP_INIT, 51199, stack-pointer reset value.
- GP_INDEX, 28, index loaded with GP_INIT on reset and clear.
- GP_INIT, 6300, global-pointer reset value.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  access enable; reads and writes occur only when high in IDLE.
- clr_start  input  1  request for a sequenced clear of the whole file.
- reg_write  input  1  write strobe.
- write_reg  input  ADDR_WIDTH  write index.
- write_data  input  DATA_WIDTH  write value.
- read_addr  input  NUM_READ*ADDR_WIDTH  packed read indices; port k uses bits [k*AW +: AW].
- read_data  output  NUM_READ*DATA_WIDTH  packed registered read data; port k uses bits [k*DW +: DW].
- rd_valid  output  1  read_data updated by the previous enabled cycle.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (async, immediate on rst=1):
  - All registers are 0, except reg[SP_INDEX]=SP_INIT and reg[GP_INDEX]=GP_INIT.
  - read_data=0, rd_valid=0, busy=0, state=IDLE, clear counter=0.
- States: IDLE, CLEAR.
- IDLE, rising edge with en=1 and clr_start=0:
  - Each port k loads read_data[k] from reg[read_addr[k]]; rd_valid<=1.
  - Read latency is 1 cycle.
  - If reg_write=1 and write_reg!=0, reg[write_reg]<=write_data.
- Bypass: if reg_write=1, write_reg!=0 and read_addr[k]==write_reg in the same enabled edge, read_data[k] gets write_data, not the old contents. This applies independently per port.
- Index 0 always reads 0; writes to index 0 are dropped.
- IDLE with en=0: no write, read_data holds, rd_valid<=0.
- IDLE with clr_start=1, regardless of en:
  - Go to CLEAR, busy<=1, counter<=1, rd_valid<=0.
  - Any same-cycle write is dropped; read_data holds.
- CLEAR, each edge:
  - reg[counter]<=its reset value (SP_INIT, GP_INIT or 0); counter increments.
  - en, reg_write and clr_start are ignored; rd_valid=0; read_data holds.
- CLEAR exit: after writing index DEPTH-1, go to IDLE and set busy<=0 on that same edge.
  - busy is high for exactly DEPTH-1 cycles.
  - The next en edge is served normally.
- Reset asserted mid-CLEAR: immediate full reset and return to IDLE; the partial sweep is discarded.
- Counter width is ADDR_WIDTH; it never wraps because exit occurs at DEPTH-1.
- All read ports are mutually independent; any ports may alias the same index.

Test Plan:
- Reset check: assert rst, release, then en=1 with read_addr={29,28} -> next cycle read_data={51199,6300}, rd_valid=1; all other indices read 0.
- Write then read: write reg5=0xDEADBEEF with en=1; next cycle read reg5 on both ports -> 0xDEADBEEF on both, one cycle after the read edge.
- Bypass: in one edge, write reg7=0x12345678 and read reg7 on port0, reg3 on port1 -> port0=0x12345678 and port1=old reg3 value. Disable bypass (different address) -> port0=old value.
- Zero register: write reg0=0xFFFFFFFF, then read reg0 -> 0. Same-edge read of reg0 during a write to reg0 -> 0.
- Clear sequence: load reg1..31 with nonzero values, pulse clr_start -> busy high for exactly 31 cycles, rd_valid=0 and writes ignored throughout. Afterwards reg29=51199, reg28=6300, all others 0.
- Reset mid-clear: assert rst 10 cycles into CLEAR -> busy drops immediately and reset values are present. A new clr_start after release restarts a full 31-cycle sweep.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-read-port register file with per-port write-to-read bypass, programmable
// SP/GP reset values and a sequenced bulk clear that restores one register per cycle.
module register_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int SP_INDEX   = 29,
   parameter int SP_INIT    = 51199,
   parameter int GP_INDEX   = 28,
   parameter int GP_INIT    = 6300
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic                           i_clr_start,
   input  logic                           i_reg_write,
   input  logic [ADDR_WIDTH-1:0]          i_write_reg,
   input  logic [DATA_WIDTH-1:0]          i_write_data,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] i_read_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] o_read_data,
   output logic                           o_rd_valid,
   output logic                           o_busy
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_next;
   logic                  r_busy, w_busy_next;
   logic                  r_rd_valid, w_rd_valid_next;
   logic                  w_access, w_wr_en, w_clr_wr;
   logic [DATA_WIDTH-1:0] r_regs [DEPTH];

   function automatic logic [DATA_WIDTH-1:0] f_init(input logic [ADDR_WIDTH-1:0] idx);
      if (idx == ADDR_WIDTH'(SP_INDEX))      return DATA_WIDTH'(SP_INIT);
      else if (idx == ADDR_WIDTH'(GP_INDEX)) return DATA_WIDTH'(GP_INIT);
      else                                   return '0;
   endfunction

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_busy_next     = r_busy;
      w_rd_valid_next = r_rd_valid;
      w_access        = 1'b0;
      w_clr_wr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A clear request wins over any same-cycle access, enabled or not.
            if (i_clr_start) begin
               w_state_next    = S_CLEAR;
               w_cnt_next      = ADDR_WIDTH'(1);
               w_busy_next     = 1'b1;
               w_rd_valid_next = 1'b0;
            end else begin
               w_access        = i_en;
               w_rd_valid_next = i_en;
            end
         end
         S_CLEAR: begin
            w_clr_wr        = 1'b1;
            w_rd_valid_next = 1'b0;
            w_cnt_next      = r_cnt + 1'b1;
            if (r_cnt == '1) begin
               w_state_next = S_IDLE;
               w_busy_next  = 1'b0;
               w_cnt_next   = '0;
            end
         end
      endcase
   end

   assign w_wr_en = w_access && i_reg_write && (i_write_reg != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_busy     <= w_busy_next;
         r_rd_valid <= w_rd_valid_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= f_init(ADDR_WIDTH'(i));
      end else if (w_clr_wr) begin
         r_regs[r_cnt] <= f_init(r_cnt);
      end else if (w_wr_en) begin
         r_regs[i_write_reg] <= i_write_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] w_addr;
         logic [DATA_WIDTH-1:0] r_data;

         assign w_addr = i_read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_data <= '0;
            end else if (w_access) begin
               if (w_addr == '0)                           r_data <= '0;
               else if (w_wr_en && (i_write_reg == w_addr)) r_data <= i_write_data;
               else                                         r_data <= r_regs[w_addr];
            end
         end

         assign o_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_data;
      end
   endgenerate

   assign o_rd_valid = r_rd_valid;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a behavioural model tracks the register
// contents and expected outputs, checked after every clock, plus literal spot checks.
module tb_register_file_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic            clk, rst, en, clr_start, reg_write;
   logic [AW-1:0]   write_reg;
   logic [DW-1:0]   write_data;
   logic [NR*AW-1:0] read_addr;
   logic [NR*DW-1:0] read_data;
   logic            rd_valid, busy;

   int n_assert = 0;
   int n_fail   = 0;

   register_file_mp #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
      .SP_INDEX(29), .SP_INIT(51199), .GP_INDEX(28), .GP_INIT(6300)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr_start(clr_start),
      .i_reg_write(reg_write), .i_write_reg(write_reg), .i_write_data(write_data),
      .i_read_addr(read_addr), .o_read_data(read_data),
      .o_rd_valid(rd_valid), .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: register contents, sweep progress and expected outputs.
   logic [DW-1:0] m_regs [DEPTH];
   logic [DW-1:0] m_rd [NR];
   logic          m_rdv, m_busy;
   int            m_clr_idx, m_clr_left;

   function automatic logic [DW-1:0] init_val(input int idx);
      if (idx == 29) return 32'd51199;
      if (idx == 28) return 32'd6300;
      return 32'd0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_regs[i] = init_val(i);
         for (int k = 0; k < NR; k++) m_rd[k] = '0;
         m_rdv = 1'b0; m_busy = 1'b0; m_clr_idx = 0; m_clr_left = 0;
      end else if (m_clr_left > 0) begin
         m_regs[m_clr_idx] = init_val(m_clr_idx);
         m_clr_idx++;
         m_clr_left--;
         m_rdv  = 1'b0;
         m_busy = (m_clr_left > 0);
      end else if (clr_start) begin
         m_clr_idx = 1; m_clr_left = DEPTH - 1; m_busy = 1'b1; m_rdv = 1'b0;
      end else if (en) begin
         for (int k = 0; k < NR; k++) begin
            int a;
            a = int'(read_addr[k*AW +: AW]);
            if (a == 0)                                    m_rd[k] = '0;
            else if (reg_write && int'(write_reg) == a)    m_rd[k] = write_data;
            else                                           m_rd[k] = m_regs[a];
         end
         if (reg_write && write_reg != '0) m_regs[write_reg] = write_data;
         m_rdv = 1'b1;
      end else begin
         m_rdv = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("rd0_model", read_data[31:0],  m_rd[0]);
      chk("rd1_model", read_data[63:32], m_rd[1]);
      chk("rd_valid_model", DW'(rd_valid), DW'(m_rdv));
      chk("busy_model",     DW'(busy),     DW'(m_busy));
   endtask

   task automatic drive(input logic e, input logic c, input logic w, input logic [AW-1:0] wr,
                        input logic [DW-1:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      en = e; clr_start = c; reg_write = w; write_reg = wr; write_data = wd;
      read_addr = {a1, a0};
      @(posedge clk); #1;
      compare_model();
      $display("t=%0t en=%0b clr=%0b we=%0b wr=%0d wd=%h ra={%0d,%0d} rd={%h,%h} v=%0b busy=%0b",
               $time, e, c, w, wr, wd, a1, a0, read_data[63:32], read_data[31:0], rd_valid, busy);
   endtask

   task automatic sweep_and_count(input string name);
      int cycles;
      cycles = 0;
      drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 5'd4, 5'd29);
      chk({name, "_busy_set"}, DW'(busy), 32'd1);
      chk({name, "_rdv_clr"},  DW'(rd_valid), 32'd0);
      for (int c = 0; c < 40 && busy; c++) begin
         cycles++;
         drive(1'b1, c[0], 1'b1, 5'd4, 32'hBAD0_0000 + c, 5'(c), 5'd4);
         if (busy) chk({name, "_rdv_busy"}, DW'(rd_valid), 32'd0);
      end
      chk({name, "_busy_cycles"}, DW'(cycles), 32'd31);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr_start = 1'b0; reg_write = 1'b0;
      write_reg = '0; write_data = '0; read_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      compare_model();
      chk("reset_rd", read_data[31:0], 32'd0);
      chk("reset_rdv", DW'(rd_valid), 32'd0);
      chk("reset_busy", DW'(busy), 32'd0);

      // Reset values of SP/GP, and every other index reads 0.
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd28, 5'd29);
      chk("reset_gp", read_data[31:0], 32'd6300);
      chk("reset_sp", read_data[63:32], 32'd51199);
      chk("reset_rdv1", DW'(rd_valid), 32'd1);
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));

      // Write then read on both ports.
      drive(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      chk("wr_rd_p0", read_data[31:0],  32'hDEADBEEF);
      chk("wr_rd_p1", read_data[63:32], 32'hDEADBEEF);

      // Bypass: same-edge write/read of reg7; port1 sees old reg3.
      drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0A0A0A0A, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd3);
      chk("bypass_p0", read_data[31:0],  32'h12345678);
      chk("bypass_p1", read_data[63:32], 32'h0A0A0A0A);
      drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h55555555, 5'd7, 5'd8);
      chk("nobypass_p0", read_data[31:0],  32'h12345678);
      chk("bypass_p1b",  read_data[63:32], 32'h55555555);

      // Register 0 is hard-wired.
      drive(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      chk("zero_same_edge", read_data[31:0], 32'd0);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
      chk("zero_read", read_data[31:0], 32'd0);

      // en=0: write dropped, read_data holds, rd_valid drops.
      drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9);
      chk("en0_hold", read_data[63:32], 32'hDEADBEEF);
      chk("en0_rdv", DW'(rd_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      chk("en0_nowrite", read_data[31:0], 32'd0);

      // Fill every register, then a full clear sweep.
      for (int i = 1; i < DEPTH; i++)
         drive(1'b1, 1'b0, 1'b1, 5'(i), 32'h10000000 + 3 * i, 5'(i), 5'(DEPTH - i));
      sweep_and_count("clr1");
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd28);
      chk("clr_sp", read_data[31:0],  32'd51199);
      chk("clr_gp", read_data[63:32], 32'd6300);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd31);
      chk("clr_r4",  read_data[31:0],  32'd0);
      chk("clr_r31", read_data[63:32], 32'd0);

      // Reset ten cycles into a sweep.
      drive(1'b1, 1'b0, 1'b1, 5'd29, 32'h1, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h5, 5'd29, 5'd5);
      drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      for (int c = 0; c < 10; c++) drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 5'd5, 5'd29);
      #2 rst = 1'b1;
      #1;
      chk("midclr_busy", DW'(busy), 32'd0);
      chk("midclr_rdv", DW'(rd_valid), 32'd0);
      chk("midclr_rd", read_data[31:0], 32'd0);
      compare_model();
      @(posedge clk); #1 rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
      chk("midclr_sp", read_data[31:0],  32'd51199);
      chk("midclr_r5", read_data[63:32], 32'd0);
      sweep_and_count("clr2");
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd28, 5'd6);
      chk("final_gp", read_data[31:0],  32'd6300);
      chk("final_r6", read_data[63:32], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
